// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops one word at a time from a synchronous FIFO read port and shifts it out
// as an asynchronous serial frame: start bit, WIDTH data bits LSB first,
// optional even-parity bit, then STOP_BITS stop bits. Every bit lasts exactly
// CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk         system clock, rising edge
//   res         asynchronous active-high reset
//   en          transmit enable, only looked at while idle
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, valid the cycle after a sampled fifo_rd_en
//   fifo_rd_en  registered one-cycle pop request
//   tx          serial line, idles high
//   busy        high whenever a frame is in progress (state != IDLE)
//   frame_done  one-cycle pulse on the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic              r_rd_en;
    logic              r_tx;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]  r_shift;
    logic              r_parity;
    logic              r_stop;

    state_t            w_state;
    logic              w_rd_en;
    logic              w_tx;
    logic [CNT_W-1:0]  w_cnt;
    logic [BIT_W-1:0]  w_bit;
    logic [WIDTH-1:0]  w_shift;
    logic              w_parity;
    logic              w_stop;

    logic              w_bit_end;
    logic              w_last_stop;
    logic [WIDTH-1:0]  w_shr;

    assign w_bit_end   = (r_cnt == CNT_LAST);
    // With a single stop bit the first stop bit is also the last one.
    assign w_last_stop = (STOP_BITS < 2) || r_stop;
    assign w_shr       = r_shift >> 1;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_rd_en  <= 1'b0;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rd_en  <= w_rd_en;
            r_tx     <= w_tx;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_stop   <= w_stop;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_rd_en  = 1'b0;
        w_tx     = r_tx;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_parity = r_parity;
        w_stop   = r_stop;

        // Baud counter free-runs 0..CLKS_PER_BIT-1 while a bit is on the line.
        if (r_state == S_START || r_state == S_DATA ||
            r_state == S_PARITY || r_state == S_STOP) begin
            w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (en && !fifo_empty) begin
                    w_rd_en = 1'b1;
                    w_state = S_REQ;
                end
            end

            // The FIFO pops on the edge leaving this state; data is ready in LOAD.
            S_REQ: begin
                w_state = S_LOAD;
            end

            S_LOAD: begin
                w_shift  = fifo_rdata;
                w_parity = ^fifo_rdata;
                w_tx     = 1'b0;
                w_cnt    = '0;
                w_bit    = '0;
                w_stop   = 1'b0;
                w_state  = S_START;
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx    = r_shift[0];
                    w_state = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_tx    = r_parity;
                            w_state = S_PARITY;
                        end else begin
                            w_tx    = 1'b1;
                            w_state = S_STOP;
                        end
                    end else begin
                        w_bit   = r_bit + 1'b1;
                        w_shift = w_shr;
                        w_tx    = w_shr[0];
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx    = 1'b1;
                    w_state = S_STOP;
                end
            end

            S_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_state = S_IDLE;
                    end else begin
                        w_stop = 1'b1;
                    end
                end
            end

            default: begin
                w_tx    = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_STOP) && w_bit_end && w_last_stop;

endmodule
